rv_imem_responder: RTL and testbench

Responder end of the instruction-fetch bus driven by the core's fetch unit. It accepts word fetch requests, serves them from a one-entry prefetch buffer or from a backing memory port with a req/gnt/rvalid handshake, and returns data under the fetch bus rule: ack in the accept cycle, data on the following cycle. It sits between the core and the instruction SRAM or external-memory bridge. Optional next-sequential-word prefetch hides part of the memory latency on straight-line code.

---
 rtl/rv_imem_pkg.sv | 26 ++
 rtl/rv_imem_responder_if.sv | 37 +++
 rtl/rv_imem_responder.sv | 142 ++++++++++++++
 tb/tb_rv_imem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rv_imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_imem_pkg
// Description : Shared types and constants for the instruction-fetch
//               responder (FSM state encoding, NOP word, address helper).
// Revision    : 1.0 - initial release
// ============================================================================
package rv_imem_pkg;

   // Responder FSM: idle, memory request pending, read data outstanding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } imem_state_t;

   // RV32I canonical NOP (addi x0, x0, 0)
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   // Next sequential word address; wraps modulo 2^30 words
   function automatic logic [29:0] next_word(input logic [29:0] word);
      return word + 30'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv_imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_imem_responder_if
// Description : Fetch bus (core side) and backing memory port (req/gnt/rvalid)
//               seen by the instruction-fetch responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_imem_responder_if;

   // Fetch bus from the core
   logic        i_cyc;
   logic [31:0] i_addr;
   logic        i_flush;
   logic        o_ack;
   logic [31:0] o_data;

   // Backing memory port
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_gnt;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;

   // Responder view
   modport slave (
      input  i_cyc, i_addr, i_flush, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      output o_ack, o_data, o_mem_req, o_mem_addr
   );

   // Core + memory view (environment driving the responder)
   modport master (
      output i_cyc, i_addr, i_flush, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
      input  o_ack, o_data, o_mem_req, o_mem_addr
   );

endinterface
`default_nettype wire

// File: rtl/rv_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : rv_imem_responder
// Description : Instruction-fetch responder. Serves word fetches from a
//               one-entry prefetch buffer or from a req/gnt/rvalid memory
//               port; ack in the accept cycle, data on the following cycle.
//               Optional next-sequential-word prefetch after every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_imem_responder
   import rv_imem_pkg::*;
#(
   parameter bit          PREFETCH   = 1'b1,
   parameter logic [31:0] RESET_DATA = RV_NOP
) (
   input  wire logic          i_clk,
   input  wire logic          i_reset,
   rv_imem_responder_if.slave bus
);

   imem_state_t state_q, state_d;
   logic [29:0] pend_addr_q, pend_addr_d;
   logic [29:0] pbuf_addr_q, pbuf_addr_d;
   logic [31:0] pbuf_data_q, pbuf_data_d;
   logic        pbuf_valid_q, pbuf_valid_d;
   logic        stale_q, stale_d;
   logic [31:0] data_q, data_d;
   logic        ack;

   logic [29:0] fetch_word;
   logic        buf_hit;
   logic        pend_match;
   logic        unused_addr_lsbs;

   // Byte offset of the fetch address plays no part in matching
   assign fetch_word       = bus.i_addr[31:2];
   assign unused_addr_lsbs = ^bus.i_addr[1:0];
   assign buf_hit          = pbuf_valid_q && (fetch_word == pbuf_addr_q);
   assign pend_match       = fetch_word == pend_addr_q;

   // Next-state, buffer update and combinational ack
   always_comb begin
      state_d      = state_q;
      pend_addr_d  = pend_addr_q;
      pbuf_addr_d  = pbuf_addr_q;
      pbuf_data_d  = pbuf_data_q;
      pbuf_valid_d = pbuf_valid_q;
      stale_d      = stale_q;
      data_d       = data_q;
      ack          = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.i_cyc) begin
               if (buf_hit) begin
                  ack    = 1'b1;
                  data_d = pbuf_data_q;
                  if (PREFETCH) begin
                     state_d     = REQ;
                     pend_addr_d = next_word(fetch_word);
                  end
               end else begin
                  state_d     = REQ;
                  pend_addr_d = fetch_word;
               end
            end
         end

         // Request is held until granted, whatever the initiator does
         REQ: begin
            if (bus.i_mem_gnt) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (bus.i_mem_rvalid) begin
               stale_d = 1'b0;
               if (!stale_q) begin
                  pbuf_addr_d  = pend_addr_q;
                  pbuf_data_d  = bus.i_mem_rdata;
                  pbuf_valid_d = 1'b1;
               end
               // A matching demand is acked even when the data is stale
               if (bus.i_cyc && pend_match) begin
                  ack    = 1'b1;
                  data_d = bus.i_mem_rdata;
                  if (PREFETCH) begin
                     state_d     = REQ;
                     pend_addr_d = next_word(pend_addr_q);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush beats any buffer load in the same cycle; the outstanding
      // request is marked stale unless it completes in this very cycle
      if (bus.i_flush) begin
         pbuf_valid_d = 1'b0;
         if ((state_q == REQ) || ((state_q == WAIT) && !bus.i_mem_rvalid)) begin
            stale_d = 1'b1;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= IDLE;
         pend_addr_q  <= '0;
         pbuf_addr_q  <= '0;
         pbuf_data_q  <= '0;
         pbuf_valid_q <= 1'b0;
         stale_q      <= 1'b0;
         data_q       <= RESET_DATA;
      end else begin
         state_q      <= state_d;
         pend_addr_q  <= pend_addr_d;
         pbuf_addr_q  <= pbuf_addr_d;
         pbuf_data_q  <= pbuf_data_d;
         pbuf_valid_q <= pbuf_valid_d;
         stale_q      <= stale_d;
         data_q       <= data_d;
      end
   end

   assign bus.o_ack      = ack;
   assign bus.o_data     = data_q;
   assign bus.o_mem_req  = (state_q == REQ);
   assign bus.o_mem_addr = {pend_addr_q, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_rv_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_imem_responder
// Description : Self-checking bench for rv_imem_responder (PREFETCH=1).
//               Cycle-by-cycle vector table plus a reset-mid-WAIT sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_imem_responder;

   localparam int NVEC = 41;

   typedef struct {
      logic        cyc;
      logic [31:0] addr;
      logic        flush;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_ack;
      logic        e_req;
      logic [31:0] e_maddr;
      logic [31:0] e_data;
   } vec_t;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;
   vec_t vt [NVEC];

   rv_imem_responder_if bus ();

   rv_imem_responder #(
      .PREFETCH   (1'b1),
      .RESET_DATA (32'h0000_0013)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic cyc, input logic [31:0] addr,
                               input logic fl, input logic gnt, input logic rv,
                               input logic [31:0] rd, input logic ea, input logic er,
                               input logic [31:0] em, input logic [31:0] ed);
      vec_t v;
      v.cyc = cyc; v.addr = addr; v.flush = fl; v.gnt = gnt; v.rvalid = rv;
      v.rdata = rd; v.e_ack = ea; v.e_req = er; v.e_maddr = em; v.e_data = ed;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_outs(input string tag, input logic ea, input logic er,
                             input logic [31:0] em, input logic [31:0] ed);
      check({tag, " ack"},      {31'd0, bus.o_ack},     {31'd0, ea});
      check({tag, " mem_req"},  {31'd0, bus.o_mem_req}, {31'd0, er});
      check({tag, " mem_addr"}, bus.o_mem_addr,         em);
      check({tag, " data"},     bus.o_data,             ed);
   endtask

   task automatic drive(input logic cyc, input logic [31:0] addr, input logic fl,
                        input logic gnt, input logic rv, input logic [31:0] rd);
      bus.i_cyc = cyc; bus.i_addr = addr; bus.i_flush = fl;
      bus.i_mem_gnt = gnt; bus.i_mem_rvalid = rv; bus.i_mem_rdata = rd;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;

      // cold miss 0x100 and sequential stream 0x104, 0x108
      vt[0]  = mk(1, 32'h100, 0, 0, 0, 0,            0, 0, 32'h0,   32'h13);
      vt[1]  = mk(1, 32'h100, 0, 1, 0, 0,            0, 1, 32'h100, 32'h13);
      vt[2]  = mk(1, 32'h100, 0, 0, 0, 0,            0, 0, 32'h100, 32'h13);
      vt[3]  = mk(1, 32'h100, 0, 0, 1, 32'hA000_0100, 1, 0, 32'h100, 32'h13);
      vt[4]  = mk(1, 32'h104, 0, 1, 0, 0,            0, 1, 32'h104, 32'hA000_0100);
      vt[5]  = mk(1, 32'h104, 0, 0, 0, 0,            0, 0, 32'h104, 32'hA000_0100);
      vt[6]  = mk(1, 32'h104, 0, 0, 1, 32'hA000_0104, 1, 0, 32'h104, 32'hA000_0100);
      vt[7]  = mk(1, 32'h108, 0, 1, 0, 0,            0, 1, 32'h108, 32'hA000_0104);
      vt[8]  = mk(1, 32'h108, 0, 0, 1, 32'hA000_0108, 1, 0, 32'h108, 32'hA000_0104);
      // cyc drop: prefetch completes unacked, later hit from buffer
      vt[9]  = mk(0, 32'h0,   0, 1, 0, 0,            0, 1, 32'h10C, 32'hA000_0108);
      vt[10] = mk(0, 32'h0,   0, 0, 1, 32'hA000_010C, 0, 0, 32'h10C, 32'hA000_0108);
      vt[11] = mk(1, 32'h10C, 0, 0, 0, 0,            1, 0, 32'h10C, 32'hA000_0108);
      vt[12] = mk(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'h110, 32'hA000_010C);
      vt[13] = mk(1, 32'h10C, 0, 0, 0, 0,            0, 1, 32'h110, 32'hA000_010C);
      // redirect 0x110 -> 0x200 while 0x110 outstanding
      vt[14] = mk(1, 32'h110, 0, 1, 0, 0,            0, 1, 32'h110, 32'hA000_010C);
      vt[15] = mk(1, 32'h200, 0, 0, 0, 0,            0, 0, 32'h110, 32'hA000_010C);
      vt[16] = mk(1, 32'h200, 0, 0, 1, 32'hA000_0110, 0, 0, 32'h110, 32'hA000_010C);
      vt[17] = mk(1, 32'h200, 0, 0, 0, 0,            0, 0, 32'h110, 32'hA000_010C);
      vt[18] = mk(1, 32'h200, 0, 1, 0, 0,            0, 1, 32'h200, 32'hA000_010C);
      vt[19] = mk(1, 32'h200, 0, 0, 1, 32'hA000_0200, 1, 0, 32'h200, 32'hA000_010C);
      // flush while prefetch 0x204 outstanding, then demand 0x204 misses
      vt[20] = mk(0, 32'h0,   0, 1, 0, 0,            0, 1, 32'h204, 32'hA000_0200);
      vt[21] = mk(0, 32'h0,   1, 0, 0, 0,            0, 0, 32'h204, 32'hA000_0200);
      vt[22] = mk(0, 32'h0,   0, 0, 1, 32'hA000_0204, 0, 0, 32'h204, 32'hA000_0200);
      vt[23] = mk(1, 32'h204, 0, 0, 0, 0,            0, 0, 32'h204, 32'hA000_0200);
      vt[24] = mk(1, 32'h204, 0, 1, 0, 0,            0, 1, 32'h204, 32'hA000_0200);
      vt[25] = mk(1, 32'h204, 0, 0, 1, 32'hB000_0204, 1, 0, 32'h204, 32'hA000_0200);
      // flush together with rvalid: matching demand still acked
      vt[26] = mk(0, 32'h0,   0, 1, 0, 0,            0, 1, 32'h208, 32'hB000_0204);
      vt[27] = mk(1, 32'h208, 1, 0, 1, 32'hA000_0208, 1, 0, 32'h208, 32'hB000_0204);
      vt[28] = mk(0, 32'h0,   0, 1, 0, 0,            0, 1, 32'h20C, 32'hA000_0208);
      vt[29] = mk(0, 32'h0,   0, 0, 1, 32'hA000_020C, 0, 0, 32'h20C, 32'hA000_0208);
      vt[30] = mk(1, 32'h20C, 0, 0, 0, 0,            1, 0, 32'h20C, 32'hA000_0208);
      vt[31] = mk(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'h210, 32'hA000_020C);
      vt[32] = mk(0, 32'h0,   0, 1, 0, 0,            0, 1, 32'h210, 32'hA000_020C);
      vt[33] = mk(0, 32'h0,   0, 0, 1, 32'hA000_0210, 0, 0, 32'h210, 32'hA000_020C);
      // wrap at 0xFFFF_FFFC, low address bits ignored
      vt[34] = mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0,       0, 0, 32'h210, 32'hA000_020C);
      vt[35] = mk(1, 32'hFFFF_FFFC, 0, 1, 0, 0,       0, 1, 32'hFFFF_FFFC, 32'hA000_020C);
      vt[36] = mk(1, 32'hFFFF_FFFF, 0, 0, 1, 32'hC000_FFFC, 1, 0, 32'hFFFF_FFFC, 32'hA000_020C);
      vt[37] = mk(1, 32'h0,   0, 1, 0, 0,            0, 1, 32'h0,   32'hC000_FFFC);
      vt[38] = mk(1, 32'h2,   0, 0, 1, 32'hC000_0000, 1, 0, 32'h0,   32'hC000_FFFC);
      // rvalid outside WAIT is ignored
      vt[39] = mk(0, 32'h0,   0, 0, 1, 32'hDEAD_BEEF, 0, 1, 32'h4,   32'hC000_0000);
      vt[40] = mk(0, 32'h0,   0, 0, 0, 0,            0, 1, 32'h4,   32'hC000_0000);

      // reset state
      drive(0, 32'h0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      #2;
      check_outs("reset", 1'b0, 1'b0, 32'h0, 32'h13);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         drive(vt[i].cyc, vt[i].addr, vt[i].flush, vt[i].gnt, vt[i].rvalid, vt[i].rdata);
         #1;
         check_outs($sformatf("v%0d", i), vt[i].e_ack, vt[i].e_req, vt[i].e_maddr, vt[i].e_data);
      end

      // reset while a request is outstanding in WAIT
      @(negedge clk);
      drive(0, 32'h0, 0, 1, 0, 32'h0);
      #1;
      check("rst_seq req", {31'd0, bus.o_mem_req}, 32'd1);
      @(negedge clk);
      drive(1, 32'h4, 0, 0, 0, 32'h0);
      #3;
      rst = 1'b1;
      #1;
      check_outs("rst_async", 1'b0, 1'b0, 32'h0, 32'h13);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 32'h0, 0, 0, 1, 32'hDEAD_0004);
      #1;
      check("rst_late_rv ack", {31'd0, bus.o_ack}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_late_rv data", bus.o_data, 32'h13);
      check("rst_late_rv req", {31'd0, bus.o_mem_req}, 32'd0);
      @(negedge clk);
      drive(1, 32'h4, 0, 0, 0, 32'h0);
      #1;
      check("rst_buf_empty ack", {31'd0, bus.o_ack}, 32'd0);
      @(posedge clk);
      #1;
      check("rst_miss req", {31'd0, bus.o_mem_req}, 32'd1);
      check("rst_miss addr", bus.o_mem_addr, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
